// File: rtl/vga_mem_arbiter_pkg.sv
// Shared types and default widths for the VGA/CPU system RAM arbiter.
package vga_mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vga_mem_port_mux.sv
// Combinational RAM port mux: a VGA-owned slot beats a CPU issue, otherwise the port idles at zero.
module vga_mem_port_mux #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              vga_owned,
  input  logic              cpu_issue,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic              vga_cs,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dat,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dat,
  output logic              mem_cs,
  output logic              mem_we
);

  always_comb begin
    mem_addr = '0;
    mem_dat  = '0;
    mem_cs   = 1'b0;
    mem_we   = 1'b0;
    if (vga_owned) begin
      // A reserved slot without cs leaves the RAM idle but still blocks the CPU.
      mem_addr = vga_addr;
      mem_cs   = vga_cs;
    end else if (cpu_issue) begin
      mem_addr = cpu_addr;
      mem_dat  = cpu_dat;
      mem_cs   = 1'b1;
      mem_we   = cpu_we;
    end
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Two-master RAM arbiter: VGA has absolute priority, CPU served in free slots (ack 2 cycles after issue).
// Optional stall counter output enabled by VGA_MEM_ARB_STALL_CNT_EN.
module vga_mem_arbiter
  import vga_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
`ifdef VGA_MEM_ARB_STALL_CNT_EN
  ,
  parameter int STALL_W = 16
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_vga_addr,
  input  logic              i_vga_cs,
  input  logic              i_vga_access,
  output logic [DATA_W-1:0] o_vga_dat,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_dat,
  input  logic              i_cpu_cs,
  input  logic              i_cpu_we,
  output logic [DATA_W-1:0] o_cpu_dat,
  output logic              o_cpu_ack,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_dat,
  output logic              o_mem_cs,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_dat,
`ifdef VGA_MEM_ARB_STALL_CNT_EN
  output logic [STALL_W-1:0] o_stall_cnt,
`endif
  output logic              o_vga_conflict
);

  state_t state, state_n;
  logic   r_reserved;
  logic   r_we;
  logic   vga_owned;
  logic   cpu_issue;

  assign vga_owned = r_reserved | i_vga_cs;
  assign o_vga_dat = i_mem_dat;

  always_comb begin
    state_n   = state;
    cpu_issue = 1'b0;
    case (state)
      IDLE: begin
        // Reset gating keeps the RAM port quiet while reset is held with cs high.
        if (i_cpu_cs && !vga_owned && !i_reset) begin
          cpu_issue = 1'b1;
          state_n   = WAIT;
        end
      end
      WAIT:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      r_reserved     <= 1'b0;
      r_we           <= 1'b0;
      o_cpu_ack      <= 1'b0;
      o_cpu_dat      <= '0;
      o_vga_conflict <= 1'b0;
    end else begin
      state      <= state_n;
      r_reserved <= i_vga_access;
      if (cpu_issue) begin
        r_we <= i_cpu_we;
      end
      if (state == WAIT) begin
        o_cpu_ack <= 1'b1;
        if (!r_we) begin
          o_cpu_dat <= i_mem_dat;
        end
      end
      if (state == DONE) begin
        o_cpu_ack <= 1'b0;
      end
      if (i_vga_cs && !r_reserved) begin
        o_vga_conflict <= 1'b1;
      end
    end
  end

`ifdef VGA_MEM_ARB_STALL_CNT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_stall_cnt <= '0;
    end else if ((state == IDLE) && i_cpu_cs && !cpu_issue && (o_stall_cnt != '1)) begin
      o_stall_cnt <= o_stall_cnt + 1'b1;
    end
  end
`endif

  vga_mem_port_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .vga_owned(vga_owned),
    .cpu_issue(cpu_issue),
    .vga_addr (i_vga_addr),
    .vga_cs   (i_vga_cs),
    .cpu_addr (i_cpu_addr),
    .cpu_dat  (i_cpu_dat),
    .cpu_we   (i_cpu_we),
    .mem_addr (o_mem_addr),
    .mem_dat  (o_mem_dat),
    .mem_cs   (o_mem_cs),
    .mem_we   (o_mem_we)
  );

endmodule
